// File: rtl/line_rasterizer.sv
// line_rasterizer
// Bresenham line walker. Takes one line command at a time and writes each
// on-screen pixel of the line, as a 16-bit colour, into a framebuffer through
// an Avalon-MM write-only master. The pitch is 2^(X_WIDTH+1) bytes per row.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   cmd_valid/ready    command handshake, accepted only while idle
//   cmd_x0/x1, y0/y1   unsigned line endpoints
//   cmd_color          RGB565 colour for every pixel of the line
//   m_address          Avalon byte address of the current pixel
//   m_write            Avalon write request (low for off-screen pixels)
//   m_writedata        pixel colour
//   m_byteenable       always 2'b11
//   m_waitrequest      Avalon stall; the request is held while it is high
//   busy               high whenever a line is in progress
//   done               one-cycle pulse in the first idle cycle after a line
module line_rasterizer #(
   parameter int          X_WIDTH = 9,
   parameter int          Y_WIDTH = 8,
   parameter int unsigned H_RES   = 320,
   parameter int unsigned V_RES   = 240,
   parameter logic [31:0] FB_BASE = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [X_WIDTH-1:0] cmd_x0,
   input  logic [X_WIDTH-1:0] cmd_x1,
   input  logic [Y_WIDTH-1:0] cmd_y0,
   input  logic [Y_WIDTH-1:0] cmd_y1,
   input  logic [15:0]        cmd_color,
   output logic [31:0]        m_address,
   output logic               m_write,
   output logic [15:0]        m_writedata,
   output logic [1:0]         m_byteenable,
   input  logic               m_waitrequest,
   output logic               busy,
   output logic               done
);

   // Error term width: wide enough for 2*err with the largest coordinate span.
   localparam int E_W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 3;
   localparam logic signed [E_W-1:0] E_ZERO = {E_W{1'b0}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   function automatic logic on_screen(input logic [X_WIDTH-1:0] px,
                                      input logic [Y_WIDTH-1:0] py);
      return (32'(px) < H_RES) && (32'(py) < V_RES);
   endfunction

   function automatic logic [31:0] pix_addr(input logic [X_WIDTH-1:0] px,
                                            input logic [Y_WIDTH-1:0] py);
      return FB_BASE + (32'(py) << (X_WIDTH + 1)) + (32'(px) << 1);
   endfunction

   function automatic logic signed [E_W-1:0] ext_x(input logic [X_WIDTH-1:0] v);
      return signed'({{(E_W-X_WIDTH){1'b0}}, v});
   endfunction

   function automatic logic signed [E_W-1:0] ext_y(input logic [Y_WIDTH-1:0] v);
      return signed'({{(E_W-Y_WIDTH){1'b0}}, v});
   endfunction

   logic [1:0]               state_q, state_d;
   logic [X_WIDTH-1:0]       x_q, x_d, x1_q, x1_d;
   logic [Y_WIDTH-1:0]       y_q, y_d, y1_q, y1_d;
   logic [15:0]              color_q, color_d;
   logic signed [E_W-1:0]    dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic                     sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
   logic                     m_write_q, m_write_d;
   logic [31:0]              m_address_q, m_address_d;
   logic [15:0]              m_writedata_q, m_writedata_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     cmd_ready_q, cmd_ready_d;

   // Setup-time and step-time intermediates
   logic signed [E_W-1:0]    xa, xb, ya, yb;
   logic signed [E_W-1:0]    dx_set, dy_set;
   logic                     sx_neg_set, sy_neg_set;
   logic signed [E_W-1:0]    e2, err_nxt;
   logic                     step_x, step_y;
   logic [X_WIDTH-1:0]       x_nxt;
   logic [Y_WIDTH-1:0]       y_nxt;
   logic                     accept, last;

   // Line parameters derived from the latched endpoints (used in SETUP).
   always_comb begin
      xa         = ext_x(x_q);
      xb         = ext_x(x1_q);
      ya         = ext_y(y_q);
      yb         = ext_y(y1_q);
      sx_neg_set = (x1_q < x_q);
      sy_neg_set = (y1_q < y_q);
      dx_set     = sx_neg_set ? (xa - xb) : (xb - xa);
      // dy is held negated: -|y1-y0|
      dy_set     = sy_neg_set ? (yb - ya) : (ya - yb);
   end

   // One Bresenham step from the current point; both axes may move together.
   always_comb begin
      e2      = err_q <<< 1;
      step_x  = (e2 >= dy_q);
      step_y  = (e2 <= dx_q);
      err_nxt = err_q + (step_x ? dy_q : E_ZERO) + (step_y ? dx_q : E_ZERO);
      x_nxt   = step_x ? (sx_neg_q ? (x_q - 1'b1) : (x_q + 1'b1)) : x_q;
      y_nxt   = step_y ? (sy_neg_q ? (y_q - 1'b1) : (y_q + 1'b1)) : y_q;
      // An off-screen pixel has m_write low and retires immediately.
      accept  = m_write_q ? ~m_waitrequest : 1'b1;
      last    = (x_q == x1_q) && (y_q == y1_q);
   end

   // Next-state logic for the FSM, the walker registers and the bus outputs.
   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      x1_d          = x1_q;
      y1_d          = y1_q;
      color_d       = color_q;
      dx_d          = dx_q;
      dy_d          = dy_q;
      err_d         = err_q;
      sx_neg_d      = sx_neg_q;
      sy_neg_d      = sy_neg_q;
      m_write_d     = m_write_q;
      m_address_d   = m_address_q;
      m_writedata_d = m_writedata_q;
      done_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               x_d     = cmd_x0;
               y_d     = cmd_y0;
               x1_d    = cmd_x1;
               y1_d    = cmd_y1;
               color_d = cmd_color;
               state_d = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            dx_d          = dx_set;
            dy_d          = dy_set;
            sx_neg_d      = sx_neg_set;
            sy_neg_d      = sy_neg_set;
            err_d         = dx_set + dy_set;
            // Present the first pixel so WRITE starts with it on the bus.
            m_write_d     = on_screen(x_q, y_q);
            m_address_d   = pix_addr(x_q, y_q);
            m_writedata_d = color_q;
            state_d       = ST_WRITE;
         end
         ST_WRITE: begin
            if (accept) begin
               if (last) begin
                  m_write_d = 1'b0;
                  done_d    = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  x_d         = x_nxt;
                  y_d         = y_nxt;
                  err_d       = err_nxt;
                  m_write_d   = on_screen(x_nxt, y_nxt);
                  m_address_d = pix_addr(x_nxt, y_nxt);
                  state_d     = ST_WRITE;
               end
            end else begin
               // Stalled: request, address and data are held as they are.
               state_d = ST_WRITE;
            end
         end
         default: begin
            m_write_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
      busy_d      = (state_d != ST_IDLE);
      cmd_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers; reset drops any line and pending bus write.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         x_q           <= {X_WIDTH{1'b0}};
         y_q           <= {Y_WIDTH{1'b0}};
         x1_q          <= {X_WIDTH{1'b0}};
         y1_q          <= {Y_WIDTH{1'b0}};
         color_q       <= 16'h0000;
         dx_q          <= E_ZERO;
         dy_q          <= E_ZERO;
         err_q         <= E_ZERO;
         sx_neg_q      <= 1'b0;
         sy_neg_q      <= 1'b0;
         m_write_q     <= 1'b0;
         m_address_q   <= 32'h0000_0000;
         m_writedata_q <= 16'h0000;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         cmd_ready_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         x1_q          <= x1_d;
         y1_q          <= y1_d;
         color_q       <= color_d;
         dx_q          <= dx_d;
         dy_q          <= dy_d;
         err_q         <= err_d;
         sx_neg_q      <= sx_neg_d;
         sy_neg_q      <= sy_neg_d;
         m_write_q     <= m_write_d;
         m_address_q   <= m_address_d;
         m_writedata_q <= m_writedata_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         cmd_ready_q   <= cmd_ready_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign m_write      = m_write_q;
   assign m_address    = m_address_q;
   assign m_writedata  = m_writedata_q;
   assign m_byteenable = 2'b11;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// tb_line_rasterizer
// Directed bench for line_rasterizer. Expected pixel writes come from a
// software Bresenham walk and go into a queue; the bus is sampled on the
// falling edge and each accepted write is popped and compared.
module tb_line_rasterizer;

   localparam logic [31:0] FB   = 32'h0004_0000;
   localparam int          HRES = 320;
   localparam int          VRES = 240;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
   } wr_t;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [8:0]  cmd_x0, cmd_x1;
   logic [7:0]  cmd_y0, cmd_y1;
   logic [15:0] cmd_color;
   logic [31:0] m_address;
   logic        m_write;
   logic [15:0] m_writedata;
   logic [1:0]  m_byteenable;
   logic        m_waitrequest;
   logic        busy;
   logic        done;

   int          total = 0;
   int          bad   = 0;
   wr_t         exp_q[$];
   logic [31:0] wr_log[$];
   int          first_k, last_k;
   int          n_wr, done_k;

   line_rasterizer #(.FB_BASE(FB)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
      .cmd_color(cmd_color),
      .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
      .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
      .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference Bresenham walk; pushes every on-screen pixel.
   task automatic model(input int x0, input int y0, input int x1, input int y1,
                        input logic [15:0] col);
      int dx, dy, sx, sy, err, e2, x, y;
      wr_t w;
      dx  = (x1 > x0) ? (x1 - x0) : (x0 - x1);
      dy  = (y1 > y0) ? (y0 - y1) : (y1 - y0);
      sx  = (x1 >= x0) ? 1 : -1;
      sy  = (y1 >= y0) ? 1 : -1;
      err = dx + dy;
      x   = x0;
      y   = y0;
      for (int i = 0; i < 2000; i++) begin
         if (x < HRES && y < VRES) begin
            w.addr = FB + 32'(y * 1024 + x * 2);
            w.data = col;
            exp_q.push_back(w);
         end
         if (x == x1 && y == y1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endtask

   // Issue one line and follow it. k counts rising edges after acceptance.
   task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                           input logic [15:0] col, input int stall_idx, input int stall_len,
                           input int abort_k, input bit junk);
      int          k, stall_seen;
      logic [31:0] s_addr;
      logic [15:0] s_data;
      wr_t         w;
      exp_q.delete();
      wr_log.delete();
      model(x0, y0, x1, y1, col);
      first_k = -1; last_k = -1; n_wr = 0; done_k = -1; stall_seen = 0;
      s_addr = 32'h0; s_data = 16'h0;
      @(negedge clk);
      chk("ready_idle", cmd_ready, 1);
      m_waitrequest = 1'b0;
      cmd_valid = 1'b1;
      cmd_x0 = 9'(x0); cmd_y0 = 8'(y0); cmd_x1 = 9'(x1); cmd_y1 = 8'(y1);
      cmd_color = col;
      @(posedge clk);
      k = 0;
      @(negedge clk);
      cmd_valid = junk;
      cmd_x0 = 9'd1; cmd_y0 = 8'd1; cmd_x1 = 9'd2; cmd_y1 = 8'd2; cmd_color = 16'h1234;
      chk("setup_busy", busy, 1);
      chk("setup_no_write", m_write, 0);
      while (k < 600) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (k == abort_k) begin
            reset = 1'b1;
            m_waitrequest = 1'b0;
            break;
         end
         if (done) begin
            done_k = k;
            cmd_valid = 1'b0;
            chk("ready_at_done", cmd_ready, 1);
            chk("no_write_at_done", m_write, 0);
            break;
         end
         if (m_write) begin
            if (n_wr == stall_idx) begin
               if (stall_seen == 0) begin
                  s_addr = m_address;
                  s_data = m_writedata;
               end else begin
                  chk("stall_addr_stable", m_address, s_addr);
                  chk("stall_data_stable", m_writedata, s_data);
               end
            end
            if (n_wr == stall_idx && stall_seen < stall_len) begin
               m_waitrequest = 1'b1;
               stall_seen++;
            end else begin
               m_waitrequest = 1'b0;
               if (exp_q.size() == 0) begin
                  chk("write_unexpected", m_write, 0);
               end else begin
                  w = exp_q.pop_front();
                  chk("wr_addr", m_address, w.addr);
                  chk("wr_data", m_writedata, w.data);
               end
               if (first_k < 0) first_k = k;
               last_k = k;
               wr_log.push_back(m_address);
               n_wr++;
            end
         end else begin
            m_waitrequest = 1'b0;
         end
      end
      if (abort_k < 0) begin
         chk("done_within_bound", (done_k >= 0), 1);
         chk("scoreboard_empty", exp_q.size(), 0);
         @(posedge clk);
         @(negedge clk);
         chk("done_one_cycle", done, 0);
         chk("idle_not_busy", busy, 0);
      end
   endtask

   initial begin
      int rx0, ry0, rx1, ry1, span;
      reset = 1'b1; cmd_valid = 1'b0; m_waitrequest = 1'b0;
      cmd_x0 = 9'd0; cmd_x1 = 9'd0; cmd_y0 = 8'd0; cmd_y1 = 8'd0; cmd_color = 16'h0000;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_m_write", m_write, 0);
      chk("rst_m_address", m_address, 32'h0);
      chk("rst_m_writedata", m_writedata, 16'h0);
      chk("rst_byteenable", m_byteenable, 2'b11);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_rst", cmd_ready, 1);

      // Horizontal line
      run_line(0, 0, 3, 0, 16'hF800, -1, 0, -1, 1'b0);
      chk("horiz_nwr", n_wr, 4);
      chk("horiz_first_k", first_k, 2 - 1);
      chk("horiz_last_k", last_k, 4);
      chk("horiz_done_k", done_k, 5);
      chk("horiz_addr3", wr_log[3], FB + 32'd6);

      // Steep line with negative x direction
      run_line(5, 5, 3, 10, 16'h07E0, -1, 0, -1, 1'b0);
      chk("steep_nwr", n_wr, 6);
      chk("steep_addr1", wr_log[1], FB + 32'h180A);
      chk("steep_addr5", wr_log[5], FB + 32'(10 * 1024 + 3 * 2));
      chk("steep_done_k", done_k, 7);

      // Single point
      run_line(7, 7, 7, 7, 16'h001F, -1, 0, -1, 1'b0);
      chk("point_nwr", n_wr, 1);
      chk("point_addr", wr_log[0], FB + 32'h1C0E);
      chk("point_done_k", done_k, 2);

      // Waitrequest held 3 cycles on the second pixel
      run_line(0, 0, 3, 0, 16'hABCD, 1, 3, -1, 1'b0);
      chk("stall_nwr", n_wr, 4);
      chk("stall_last_k", last_k, 7);
      chk("stall_done_k", done_k, 8);

      // Clipping at the right edge
      run_line(318, 0, 321, 0, 16'h5555, -1, 0, -1, 1'b0);
      chk("clip_nwr", n_wr, 2);
      chk("clip_addr0", wr_log[0], FB + 32'd636);
      chk("clip_addr1", wr_log[1], FB + 32'd638);
      chk("clip_done_k", done_k, 5);

      // cmd_valid held high with other coordinates while busy
      run_line(2, 3, 9, 5, 16'h0F0F, -1, 0, -1, 1'b1);
      chk("junk_nwr", n_wr, 8);
      chk("junk_done_k", done_k, 9);

      // Random lines, some partly off-screen
      for (int r = 0; r < 6; r++) begin
         rx0 = $urandom_range(340, 0); rx1 = $urandom_range(340, 0);
         ry0 = $urandom_range(250, 0); ry1 = $urandom_range(250, 0);
         run_line(rx0, ry0, rx1, ry1, 16'($urandom), -1, 0, -1, 1'b0);
         span = (rx1 > rx0) ? (rx1 - rx0) : (rx0 - rx1);
         if (((ry1 > ry0) ? (ry1 - ry0) : (ry0 - ry1)) > span)
            span = (ry1 > ry0) ? (ry1 - ry0) : (ry0 - ry1);
         chk("rand_done_k", done_k, span + 2);
      end

      // Reset during the third pixel
      run_line(0, 0, 9, 0, 16'h7777, -1, 0, 3, 1'b0);
      chk("abort_nwr", n_wr, 2);
      @(posedge clk);
      @(negedge clk);
      chk("abort_m_write", m_write, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("abort_no_done", done, 0);
      end
      run_line(1, 2, 4, 2, 16'h3C3C, -1, 0, -1, 1'b0);
      chk("after_abort_nwr", n_wr, 4);
      chk("after_abort_done_k", done_k, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
